// File: rtl/div_controller_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, iteration count
// and the conditional two's-complement helper used for sign handling.
package div_controller_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    localparam int          DIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // 32-bit negate when en is set; 0x8000_0000 maps onto itself
    function automatic logic [31:0] cneg32(logic [31:0] x, logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_controller_if.sv
// EX-stage divide handshake: operands and control in, {HI,LO} result and completion out.
interface div_controller_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        sign;
    logic        is_busbusy;
    logic [63:0] P;
    logic        opreat_over;

    modport master (output A, B, start, sign, is_busbusy, input  P, opreat_over);
    modport slave  (input  A, B, start, sign, is_busbusy, output P, opreat_over);
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step (
    input  logic [31:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic [31:0] quo_next
);
    logic [32:0] trial;
    logic [32:0] diff;

    // bit 32 of the 33-bit difference is the borrow
    always_comb begin
        trial = {rem, quo[31]};
        diff  = trial - {1'b0, divisor};
        if (!diff[32]) begin
            rem_next = diff[31:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = trial[31:0];
            quo_next = {quo[30:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_controller.sv
// DIV/DIVU controller: magnitude divide over 32 restoring steps, then sign fix-up
// into the registered {remainder, quotient} result. Divide-by-zero finishes at once.
module div_controller
    import div_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    div_controller_if.slave dif
);
    div_state_e  state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] p_q, p_d;
    logic [31:0] rem_nxt, quo_nxt;

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        p_d       = p_q;
        case (state_q)
            DIV_IDLE: begin
                if (dif.start) begin
                    if (dif.B != 32'd0) begin
                        // quotient register doubles as the dividend shifter
                        quo_d     = cneg32(dif.A, dif.sign & dif.A[31]);
                        dvs_d     = cneg32(dif.B, dif.sign & dif.B[31]);
                        neg_quo_d = dif.sign & (dif.A[31] ^ dif.B[31]);
                        neg_rem_d = dif.sign & dif.A[31];
                        rem_d     = 32'd0;
                        cnt_d     = 5'd0;
                        state_d   = DIV_CALC;
                    end else begin
                        p_d     = {dif.A, DIV_ZERO_Q};
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_CALC: begin
                if (!dif.start) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(DIV_ITER - 1)) state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (!dif.start) begin
                    state_d = DIV_IDLE;
                end else begin
                    p_d     = {cneg32(rem_q, neg_rem_q), cneg32(quo_q, neg_quo_q)};
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!dif.start || !dif.is_busbusy) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            p_q       <= p_d;
        end
    end

    assign dif.P           = p_q;
    assign dif.opreat_over = (state_q == DIV_DONE) | ~dif.start;

endmodule

// File: tb/tb_div_controller.sv
// Bench for div_controller: directed vector table, handshake corner sequences,
// and random operands checked against an arithmetic divide model.
module tb_div_controller;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    div_controller_if dif ();

    div_controller dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] exp_p;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; signed divide truncates toward zero
    // and the remainder takes the dividend's sign.
    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a rising edge with the DUT idle and start low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_p, input string nm);
        int n;
        dif.A = a; dif.B = b; dif.sign = s; dif.is_busbusy = 1'b0; dif.start = 1'b1;
        n = 0;
        #1;
        while (dif.opreat_over !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " latency"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd34);
        chk({nm, " P"}, dif.P, exp_p);
        dif.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        logic        rs;

        vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2,          32'd14}};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1,          32'hFFFF_FFFD}};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0,          32'h8000_0000}};
        vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000,  32'h0}};
        vecs[5] = '{32'h1234_5678,  32'd0,          1'b0, {32'h1234_5678,  32'hFFFF_FFFF}};
        vecs[6] = '{32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678,  32'hFFFF_FFFF}};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0,          32'hFFFF_FFFF}};
        vecs[8] = '{32'd0,          32'd5,          1'b1, {32'h0,          32'h0}};
        vecs[9] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE,  32'h0000_000E}};

        rst = 1'b0;
        dif.A = '0; dif.B = '0; dif.sign = 1'b0; dif.start = 1'b0; dif.is_busbusy = 1'b0;
        #12;
        chk("reset P", dif.P, 64'h0);
        chk("reset opreat_over idle", 64'(dif.opreat_over), 64'd1);
        dif.start = 1'b1; #1;
        chk("reset opreat_over start", 64'(dif.opreat_over), 64'd0);
        dif.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_p, $sformatf("vec%0d", i));

        // result held while downstream is busy, then back-to-back operation
        dif.A = 32'd50; dif.B = 32'd5; dif.sign = 1'b0; dif.is_busbusy = 1'b1; dif.start = 1'b1;
        n = 0; #1;
        while (dif.opreat_over !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("busy latency", 64'(n), 64'd34);
        chk("busy P", dif.P, {32'd0, 32'd10});
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("busy hold opreat_over", 64'(dif.opreat_over), 64'd1);
            chk("busy hold P", dif.P, {32'd0, 32'd10});
        end
        dif.is_busbusy = 1'b0; dif.A = 32'd9; dif.B = 32'd3;
        @(posedge clk); #1;
        chk("release idle opreat_over", 64'(dif.opreat_over), 64'd0);
        n = 0;
        while (dif.opreat_over !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        chk("b2b latency", 64'(n), 64'd34);
        chk("b2b P", dif.P, {32'd0, 32'd3});
        dif.start = 1'b0;
        @(posedge clk); #1;

        // abort in CALC
        dif.A = 32'd1000; dif.B = 32'd3; dif.start = 1'b1;
        repeat (11) @(posedge clk);
        #1; dif.start = 1'b0; #1;
        chk("abort opreat_over", 64'(dif.opreat_over), 64'd1);
        @(posedge clk); #1;
        chk("abort P kept", dif.P, {32'd0, 32'd3});
        chk("abort idle opreat_over", 64'(dif.opreat_over), 64'd1);
        run_op(32'd21, 32'd4, 1'b0, {32'd1, 32'd5}, "post-abort");

        // asynchronous reset mid-CALC
        dif.A = 32'd777; dif.B = 32'd5; dif.start = 1'b1;
        repeat (15) @(posedge clk);
        #2; rst = 1'b0; #1;
        chk("mid reset P", dif.P, 64'h0);
        dif.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(32'd777, 32'd5, 1'b0, {32'd2, 32'd155}, "post-reset");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
